// File: rtl/qpmm_rr_scheduler.sv
// Round-robin front end that shares one pipelined QPMM multiplier among N_REQ requesters.
// A tag pipe matched to the multiplier latency steers each product back to its issuer.
module qpmm_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int W_FP    = 272,
  parameter int LATENCY = 58,
  parameter int MAX_OUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*W_FP-1:0]   req_a,
  input  logic [N_REQ*W_FP-1:0]   req_b,
  output logic [W_FP-1:0]         qpmm_a,
  output logic [W_FP-1:0]         qpmm_b,
  input  logic [W_FP-1:0]         qpmm_z,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [W_FP-1:0]         rsp_z,
  output logic                    busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]               rr_ptr_r;
  logic [N_REQ-1:0][CW-1:0]    credit_r;
  // One extra stage covers the operand register in front of the multiplier.
  logic [LATENCY:0]            tag_valid_r;
  logic [LATENCY:0][IW-1:0]    tag_id_r;

  logic [N_REQ-1:0]            elig_s;
  logic [N_REQ-1:0]            grant_s;
  logic [N_REQ-1:0]            ret_s;
  logic                        found_s;
  logic                        take_s;
  logic                        credit_nz_s;
  logic [IW-1:0]               grant_id_s;
  logic [W_FP-1:0]             sel_a_s;
  logic [W_FP-1:0]             sel_b_s;
  int                          idx_s;

  // Eligibility and first-eligible search starting at the round-robin pointer
  always_comb begin
    elig_s     = {N_REQ{1'b0}};
    found_s    = 1'b0;
    grant_id_s = {IW{1'b0}};
    idx_s      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_valid[i] & (credit_r[i] < CW'(MAX_OUT));
    end
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = int'(rr_ptr_r) + k;
      if (idx_s >= N_REQ) begin
        idx_s = idx_s - N_REQ;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && elig_s[IW'(idx_s)]) begin
        found_s    = 1'b1;
        grant_id_s = IW'(idx_s);
      end else begin
        found_s    = found_s;
      end
    end
    take_s = found_s & ~rst;
  end

  // Operand select, grant one-hot, return decode and credit summary
  always_comb begin
    sel_a_s     = {W_FP{1'b0}};
    sel_b_s     = {W_FP{1'b0}};
    grant_s     = {N_REQ{1'b0}};
    ret_s       = {N_REQ{1'b0}};
    credit_nz_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_s == IW'(i)) begin
        sel_a_s = req_a[i*W_FP +: W_FP];
        sel_b_s = req_b[i*W_FP +: W_FP];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
      credit_nz_s = credit_nz_s | (credit_r[i] != {CW{1'b0}});
    end
    if (take_s) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = {N_REQ{1'b0}};
    end
    if (tag_valid_r[LATENCY]) begin
      ret_s[tag_id_r[LATENCY]] = 1'b1;
    end else begin
      ret_s = {N_REQ{1'b0}};
    end
  end

  assign req_ready = grant_s;
  assign busy      = ~rst & (credit_nz_s | take_s);

  // Operand register, pointer, tag pipe and response register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= {IW{1'b0}};
      qpmm_a      <= {W_FP{1'b0}};
      qpmm_b      <= {W_FP{1'b0}};
      tag_valid_r <= {(LATENCY+1){1'b0}};
      tag_id_r    <= {((LATENCY+1)*IW){1'b0}};
      rsp_valid   <= {N_REQ{1'b0}};
      rsp_z       <= {W_FP{1'b0}};
    end else begin
      if (take_s) begin
        qpmm_a   <= sel_a_s;
        qpmm_b   <= sel_b_s;
        rr_ptr_r <= (grant_id_s == IW'(N_REQ - 1)) ? {IW{1'b0}} : grant_id_s + IW'(1);
      end
      tag_valid_r <= {tag_valid_r[LATENCY-1:0], take_s};
      tag_id_r    <= {tag_id_r[LATENCY-1:0], grant_id_s};
      rsp_valid   <= ret_s;
      if (tag_valid_r[LATENCY]) begin
        rsp_z <= qpmm_z;
      end
    end
  end

  // Outstanding-operation credits; issue and return together cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r <= {(N_REQ*CW){1'b0}};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        case ({grant_s[i], ret_s[i]})
          2'b10:   credit_r[i] <= credit_r[i] + CW'(1);
          2'b01:   credit_r[i] <= credit_r[i] - CW'(1);
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

  qpmm_rr_scheduler_chk #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT), .CW(CW)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .inc    (grant_s),
    .dec    (ret_s),
    .credit (credit_r)
  );

endmodule

// Credit counter sanity checks: no return without an outstanding op, no issue beyond the limit.
module qpmm_rr_scheduler_chk #(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 8,
  parameter int CW      = 4
) (
  input logic                  clk,
  input logic                  rst,
  input logic [N_REQ-1:0]      inc,
  input logic [N_REQ-1:0]      dec,
  input logic [N_REQ-1:0][CW-1:0] credit
);

  // Flag underflow and overflow of every credit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        assert (!(dec[i] && !inc[i] && credit[i] == {CW{1'b0}}));
        assert (!(inc[i] && !dec[i] && credit[i] == CW'(MAX_OUT)));
      end
    end
  end

endmodule

// File: tb/tb_qpmm_rr_scheduler.sv
// Self-checking bench: a queue-based reference model of arbitration, credits and return order,
// with a behavioural modular multiplier standing in for the QPMM pipeline.
module tb_qpmm_rr_scheduler;

  localparam int N = 4;
  localparam int W = 272;
  localparam int L = 58;
  localparam int M = 8;
  localparam logic [W-1:0] P = 272'd2305843009213693951;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   qpmm_a, qpmm_b, qpmm_z, rsp_z;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qpmm_rr_scheduler #(.N_REQ(N), .W_FP(W), .LATENCY(L), .MAX_OUT(M)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .qpmm_a(qpmm_a), .qpmm_b(qpmm_b), .qpmm_z(qpmm_z),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .busy(busy)
  );

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    prod = prod % {{W{1'b0}}, P};
    return prod[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_fp();
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < 9; j++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Behavioural multiplier: operands presented in a cycle give Z exactly L cycles later
  logic [W-1:0] zpipe [L];
  always @(posedge clk) begin
    zpipe[0] <= mulmod(qpmm_a, qpmm_b);
    for (int k = 1; k < L; k++) zpipe[k] <= zpipe[k-1];
  end
  assign qpmm_z = zpipe[L-1];

  // Reference model: outstanding queue in issue order, per-requester counts, RR pointer
  typedef struct { int id; logic [W-1:0] z; int due; } exp_t;
  exp_t         q[$];
  int           cnt [N];
  int           ptr = 0;
  int           edge_n = 0;
  logic [N-1:0] exp_ready = '0;
  logic [N-1:0] exp_rsp_valid = '0;
  logic [W-1:0] exp_rsp_z = '0;
  logic         exp_busy = 1'b0;

  always @(negedge clk) begin
    bit found;
    int idx;
    found = 0;
    exp_ready = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (!found && req_valid[idx] && cnt[idx] < M) begin
          exp_ready[idx] = 1'b1;
          found = 1;
        end
      end
    end
    exp_busy = 1'b0;
    for (int i = 0; i < N; i++) if (cnt[i] > 0) exp_busy = 1'b1;
    exp_busy = !rst && (exp_busy || (exp_ready != '0));
  end

  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      ptr = 0;
      exp_rsp_valid = '0;
      exp_rsp_z = '0;
    end else begin
      exp_rsp_valid = '0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_rsp_valid[q[0].id] = 1'b1;
        exp_rsp_z = q[0].z;
        cnt[q[0].id]--;
        void'(q.pop_front());
      end
      for (int g = 0; g < N; g++) begin
        if (exp_ready[g]) begin
          e.id = g;
          e.z = mulmod(req_a[g*W +: W], req_b[g*W +: W]);
          e.due = edge_n + L + 1;
          q.push_back(e);
          cnt[g]++;
          ptr = (g + 1) % N;
        end
      end
    end
  end

  task automatic tick(input logic [N-1:0] v);
    @(posedge clk); #1;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rand_fp();
      req_b[i*W +: W] = rand_fp();
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, busy, rsp_z, qpmm_a, qpmm_b} !== '0) begin
      errors++;
      $display("FAIL reset ready=%b rsp=%b busy=%b z=%h a=%h want all zero", req_ready, rsp_valid, busy, rsp_z, qpmm_a);
    end
  endtask

  task automatic test_single_op();
    int lat;
    logic [N-1:0] got_v;
    logic [W-1:0] got_z;
    lat = -1; got_v = '0; got_z = '0;
    tick(4'b0100);
    req_a[2*W +: W] = W'(1);
    req_b[2*W +: W] = W'(5);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant ready=%b want 0100", req_ready);
    end
    for (int c = 1; c <= 100; c++) begin
      tick('0);
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL single_cyc c=%0d ready=%b/%b rsp=%b/%b busy=%b/%b", c, req_ready, exp_ready, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
      if (lat < 0 && rsp_valid != '0) begin lat = c; got_v = rsp_valid; got_z = rsp_z; end
    end
    checks++;
    if (lat != L + 2 || got_v !== 4'b0100 || got_z !== W'(5)) begin
      errors++; $display("FAIL single_rsp lat=%0d rsp=%b z=%h want lat=%0d rsp=0100 z=5", lat, got_v, got_z, L + 2);
    end
  endtask

  task automatic test_round_robin();
    int gcnt [N];
    int gseq[$];
    int rseq[$];
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      tick(4'hF);
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL rr_cyc c=%0d ready=%b/%b rsp=%b/%b busy=%b/%b", c, req_ready, exp_ready, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_first ready=%b want 1000", req_ready); end
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) begin gcnt[i]++; gseq.push_back(i); end
    end
    // Each requester is capped at M outstanding before its first product returns.
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gcnt[i] != M) begin errors++; $display("FAIL rr_count id=%0d got=%0d want=%0d", i, gcnt[i], M); end
    end
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      tick('0);
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL rr_drain c=%0d rsp=%b/%b busy=%b/%b", c, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
      for (int i = 0; i < N; i++) if (rsp_valid[i]) rseq.push_back(i);
    end
    checks++;
    if (rseq != gseq) begin errors++; $display("FAIL rr_order got %0d rsps want %0d in grant order", rseq.size(), gseq.size()); end
  endtask

  task automatic test_credit_limit();
    int early, mid;
    logic at60;
    early = 0; mid = 0; at60 = 1'b0;
    for (int c = 0; c < 62; c++) begin
      tick(4'b0001);
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL credit_cyc c=%0d ready=%b/%b rsp=%b/%b busy=%b/%b", c, req_ready, exp_ready, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
      if (c < 20 && req_ready[0]) early++;
      if (c >= 8 && c < 60 && req_ready[0]) mid++;
      if (c == 60) at60 = req_ready[0];
    end
    checks++;
    if (early != M || mid != 0 || at60 !== 1'b1) begin
      errors++; $display("FAIL credit_limit early=%0d mid=%0d regrant60=%b want %0d 0 1", early, mid, at60, M);
    end
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      tick('0);
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++; $display("FAIL credit_drain c=%0d rsp=%b/%b busy=%b/%b", c, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
    end
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL credit_idle busy=%b pending=%0d want 0 0", busy, q.size()); end
  endtask

  task automatic test_back_to_back();
    int grants;
    grants = 0;
    for (int c = 0; c < 180; c++) begin
      tick(4'b0010);
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL b2b_cyc c=%0d ready=%b/%b rsp=%b/%b busy=%b/%b", c, req_ready, exp_ready, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
      if (req_ready[1]) grants++;
    end
    checks++;
    if (grants != 3 * M) begin errors++; $display("FAIL b2b_rate grants=%0d want %0d", grants, 3 * M); end
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      tick('0);
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++; $display("FAIL b2b_drain c=%0d rsp=%b/%b busy=%b/%b", c, rsp_valid, exp_rsp_valid, busy, exp_busy);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int ops, seen, lat;
    ops = 0; seen = 0; lat = -1;
    for (int c = 0; c < 400 && ops < 15; c++) begin
      tick(4'($urandom_range(1, 15)));
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++; $display("FAIL mid_cyc c=%0d ready=%b/%b busy=%b/%b", c, req_ready, exp_ready, busy, exp_busy);
      end
      if (exp_ready != '0) ops++;
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      tick('0);
      if (rsp_valid != '0) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_flush rsp_cycles=%0d busy=%b want 0 0", seen, busy); end
    tick(4'b0010);
    for (int c = 1; c <= 100; c++) begin
      tick('0);
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++; $display("FAIL mid_fresh c=%0d rsp=%b/%b z=%h/%h", c, rsp_valid, exp_rsp_valid, rsp_z, exp_rsp_z);
      end
      if (lat < 0 && rsp_valid != '0) lat = c;
    end
    checks++;
    if (lat != L + 2) begin errors++; $display("FAIL mid_latency got=%0d want=%0d", lat, L + 2); end
  endtask

  task automatic test_soak();
    int ops;
    ops = 0;
    for (int c = 0; c < 40000 && ops < 10000; c++) begin
      tick(4'($urandom()));
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_z} !== {exp_ready, exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++;
        $display("FAIL soak c=%0d ready=%b/%b rsp=%b/%b busy=%b/%b z=%h/%h", c, req_ready, exp_ready, rsp_valid, exp_rsp_valid, busy, exp_busy, rsp_z, exp_rsp_z);
      end
      if (exp_ready != '0) ops++;
    end
    for (int c = 0; c < 200 && q.size() > 0; c++) begin
      tick('0);
      checks++;
      if ({rsp_valid, busy, rsp_z} !== {exp_rsp_valid, exp_busy, exp_rsp_z}) begin
        errors++; $display("FAIL soak_drain c=%0d rsp=%b/%b z=%h/%h", c, rsp_valid, exp_rsp_valid, rsp_z, exp_rsp_z);
      end
    end
    checks++;
    if (ops != 10000 || q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL soak_total ops=%0d pending=%0d busy=%b want 10000 0 0", ops, q.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_credit_limit();
    test_back_to_back();
    test_reset_midflight();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
